// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-FIFO definitions: default sizing and the per-cycle
// operation decode used by the FIFO control logic.
package uart_rx_fifo_pkg;

  // Default geometry of the receive queue.
  localparam int UART_FIFO_DEPTH     = 16;
  localparam int UART_FIFO_THRESHOLD = 8;
  localparam int UART_DATA_W         = 8;

  // What the queue does with its inputs in a given cycle.
  typedef struct packed {
    logic push;  // byte is written at the tail
    logic pop;   // head entry is consumed
    logic drop;  // byte arrived while full with no room made: overrun
  } fifo_op_t;

  // Resolve push/pop/drop from the requests and the current fill flags.
  // A full queue still accepts a byte when a pop frees a slot the same cycle.
  function automatic fifo_op_t decode_op(input logic rx_end, input logic rd_en,
                                         input logic full, input logic empty);
    fifo_op_t op;
    op.pop  = rd_en & ~empty;
    op.push = rx_end & (~full | op.pop);
    op.drop = rx_end & full & ~op.pop;
    return op;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 storage array: synchronous write, asynchronous read, no reset.
module uart_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Store the incoming byte at the write address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte queue for a UART: show-ahead read, sticky overrun,
// fill-level interrupt and synchronous flush. Storage lives in uart_fifo_ram.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH     = UART_FIFO_DEPTH,
  parameter int THRESHOLD = UART_FIFO_THRESHOLD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_end,
  input  logic [7:0]               rx_data,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     ovr_clr,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_THR  = CW'(THRESHOLD);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;
  logic [CW-1:0] w_count_next;
  logic [7:0]    w_ram_rdata;
  logic          w_we;
  fifo_op_t      w_op;

  // Flags come only from the registered count, so they never glitch on inputs.
  assign empty   = (r_count == '0);
  assign full    = (r_count == C_FULL);
  assign irq     = (r_count >= C_THR);
  assign count   = r_count;
  assign overrun = r_overrun;

  // Stale memory contents stay hidden behind the empty flag.
  assign rd_data = empty ? 8'h00 : w_ram_rdata;

  assign w_op = decode_op(rx_end, rd_en, full, empty);

  // A flushed or reset cycle never writes, so nothing leaks past either.
  assign w_we = w_op.push & ~flush & ~rst;

  // Next fill level: simultaneous push and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    if (w_op.push && !w_op.pop) begin
      w_count_next = r_count + C_ONE;
    end else if (w_op.pop && !w_op.push) begin
      w_count_next = r_count - C_ONE;
    end
  end

  // Pointer and count registers; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_op.push) r_wptr <= r_wptr + 1'b1;
      if (w_op.pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Sticky overrun: a new drop beats a same-cycle clear; flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_op.drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (rx_data),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, THRESHOLD=8): a vector table
// for single-cycle behaviour plus sequences for fill, overrun, flush, reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_end;
  logic [7:0] rx_data;
  logic       rd_en;
  logic       flush;
  logic       ovr_clr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rx_end;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       flush;
    logic       ovr_clr;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       irq;
    logic       ovr;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .THRESHOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_end  (rx_end),
    .rx_data (rx_data),
    .rd_en   (rd_en),
    .flush   (flush),
    .ovr_clr (ovr_clr),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun),
    .irq     (irq)
  );

  function automatic vec_t mk(input logic re, input logic [7:0] d, input logic rd,
                              input logic fl, input logic oc, input logic [4:0] c,
                              input logic e, input logic f, input logic i,
                              input logic o, input logic [7:0] q);
    vec_t v;
    v.rx_end = re; v.rx_data = d; v.rd_en = rd; v.flush = fl; v.ovr_clr = oc;
    v.cnt = c; v.emp = e; v.ful = f; v.irq = i; v.ovr = o; v.rd = q;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [4:0] c, input logic e,
                           input logic f, input logic i, input logic o,
                           input logic [7:0] q);
    chk({tag, ".count"},   32'(count),   32'(c));
    chk({tag, ".empty"},   32'(empty),   32'(e));
    chk({tag, ".full"},    32'(full),    32'(f));
    chk({tag, ".irq"},     32'(irq),     32'(i));
    chk({tag, ".overrun"}, 32'(overrun), 32'(o));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(q));
    $display("%s: count=%0d empty=%0b full=%0b irq=%0b ovr=%0b rd=%02h",
             tag, count, empty, full, irq, overrun, rd_data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rx_end = 1'b0; rx_data = 8'h00; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    rx_end = 1'b1; rx_data = d;
    tick();
    rx_end = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Vector table: inputs for one cycle, expected outputs after that edge.
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 0, 0, 0, 0, 8'hA5));
    tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 2, 0, 0, 0, 0, 8'hA5));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0, 8'h3C));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h11, 1, 0, 0, 1, 0, 0, 0, 0, 8'h11));
    tbl.push_back(mk(1, 8'h22, 1, 0, 0, 1, 0, 0, 0, 0, 8'h22));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk(1, 8'(k), 0, 0, 0, 5'(k), 0, 0, 0, 0, 8'h01));
    tbl.push_back(mk(1, 8'h08, 0, 0, 0, 8, 0, 0, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 7, 0, 0, 0, 0, 8'h02));
    tbl.push_back(mk(1, 8'h09, 0, 0, 0, 8, 0, 0, 1, 0, 8'h02));
    tbl.push_back(mk(1, 8'h33, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));

    idle_inputs();
    rst = 1'b1;
    #2;
    chk_state("reset_hold", 0, 1, 0, 0, 0, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_state("reset_release", 0, 1, 0, 0, 0, 8'h00);

    foreach (tbl[n]) begin
      rx_end = tbl[n].rx_end; rx_data = tbl[n].rx_data; rd_en = tbl[n].rd_en;
      flush = tbl[n].flush; ovr_clr = tbl[n].ovr_clr;
      tick();
      idle_inputs();
      chk_state($sformatf("vec%0d", n), tbl[n].cnt, tbl[n].emp, tbl[n].ful,
                tbl[n].irq, tbl[n].ovr, tbl[n].rd);
    end

    // Fill to DEPTH, then a 17th byte is dropped and flags overrun.
    for (int k = 0; k < 16; k++) push(8'(k));
    chk_state("fill16", 16, 0, 1, 1, 0, 8'h00);
    push(8'hFF);
    chk_state("drop17", 16, 0, 1, 1, 1, 8'h00);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain_seq%0d", k), 32'(rd_data), 32'(k));
      pop();
    end
    chk_state("drained", 0, 1, 0, 0, 1, 8'h00);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk_state("ovr_cleared", 0, 1, 0, 0, 0, 8'h00);

    // Full queue: push and pop in one cycle keep it full without overrun.
    for (int k = 0; k < 16; k++) push(8'h40 + 8'(k));
    rx_end = 1'b1; rx_data = 8'hAB; rd_en = 1'b1;
    tick();
    idle_inputs();
    chk_state("full_push_pop", 16, 0, 1, 1, 0, 8'h41);
    // A drop coinciding with ovr_clr must leave overrun set.
    rx_end = 1'b1; rx_data = 8'hCD; ovr_clr = 1'b1;
    tick();
    idle_inputs();
    chk_state("clr_vs_drop", 16, 0, 1, 1, 1, 8'h41);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("clr_alone.overrun", 32'(overrun), 32'(0));
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("wrap_seq%0d", k), 32'(rd_data), 32'(8'h40 + 8'(k)));
      pop();
    end
    chk_state("tail_byte", 1, 0, 0, 0, 0, 8'hAB);
    pop();
    chk_state("tail_popped", 0, 1, 0, 0, 0, 8'h00);

    // Flush beats a same-cycle push; the next push is seen alone.
    for (int k = 0; k < 5; k++) push(8'h60 + 8'(k));
    chk_state("five_stored", 5, 0, 0, 0, 0, 8'h60);
    flush = 1'b1; rx_end = 1'b1; rx_data = 8'h99;
    tick();
    idle_inputs();
    chk_state("flush_push", 0, 1, 0, 0, 0, 8'h00);
    push(8'h77);
    chk_state("after_flush", 1, 0, 0, 0, 0, 8'h77);
    pop();

    // Build count=3 with overrun=1, then reset asynchronously mid-cycle.
    for (int k = 0; k < 16; k++) push(8'h80 + 8'(k));
    push(8'hEE);
    for (int k = 0; k < 13; k++) pop();
    chk_state("pre_reset", 3, 0, 0, 0, 1, 8'h8D);
    #3;
    rx_end = 1'b1; rx_data = 8'h5A;
    rst = 1'b1;
    #1;
    chk_state("async_reset", 0, 1, 0, 0, 0, 8'h00);
    tick();
    chk_state("reset_push_discard", 0, 1, 0, 0, 0, 8'h00);
    rst = 1'b0;
    idle_inputs();
    pop();
    pop();
    chk_state("empty_reads", 0, 1, 0, 0, 0, 8'h00);
    push(8'h12);
    chk_state("first_after_reset", 1, 0, 0, 0, 0, 8'h12);
    pop();
    chk_state("final", 0, 1, 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
